// File: rtl/lmem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// lmem_port_arbiter_if
// Bundles the three requester command lanes, their grant/read-return signals
// and the single layer-memory port into one interface.
//
// Requester side (per requester i, fields packed i-major):
//   req[i], lock[i], we[i]     command valid, burst lock, 1=write/0=read
//   sel[i*SW+:SW]              target memory select
//   addr[i*AW+:AW]             word address
//   wdata[i*DW+:DW]            write data
//   gnt[i]                     requester i owns the memory port
//   rvalid[i], rdata           registered read return for requester i
// Memory side:
//   cwr, crd, csel             registered write/read strobes and select
//   caddr_wr, caddr_rd         registered write/read addresses
//   cdata_wr, cdata_rd         registered write data / read data from memory
//
// Modports:
//   slave  - the arbiter
//   master - the requesters and the memory (e.g. a testbench)
// -----------------------------------------------------------------------------
interface lmem_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 20,
  parameter int SW = 3
) ();
  localparam int NREQ = 3;

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ-1:0]    we;
  logic [NREQ*SW-1:0] sel;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    rvalid;

  logic               cwr;
  logic               crd;
  logic [SW-1:0]      csel;
  logic [AW-1:0]      caddr_wr;
  logic [AW-1:0]      caddr_rd;
  logic [DW-1:0]      cdata_wr;
  logic [DW-1:0]      cdata_rd;

  modport slave (
    input  req, lock, we, sel, addr, wdata, cdata_rd,
    output gnt, rdata, rvalid, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr
  );

  modport master (
    output req, lock, we, sel, addr, wdata, cdata_rd,
    input  gnt, rdata, rvalid, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr
  );
endinterface

// File: rtl/lmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// lmem_port_arbiter
// Shares the single layer-memory port among three requesters:
//   r0 = conv/ReLU writer (L0), r1 = max-pool engine, r2 = host/debug readback.
// Whole bursts are granted; every memory command is registered, and read data
// is returned one cycle after the read strobe to the requester that issued it,
// even if the grant has moved on in the meantime.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high reset
//   bus    lmem_port_arbiter_if.slave (requester lanes + memory port)
//
// Parameters:
//   AW, DW, SW  address / data / select widths
//   MAX_BURST   transfers per grant while another requester waits (>= 1);
//               a locked owner is never preempted
//
// Configuration macro:
//   LMEM_ARB_RR_EN  defined: round-robin winner search starting at rr_ptr.
//                   undefined: fixed priority r0 > r1 > r2 (rr_ptr stays 0).
// -----------------------------------------------------------------------------
module lmem_port_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 20,
  parameter int SW        = 3,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  lmem_port_arbiter_if.slave   bus
);
  localparam int NREQ = 3;
  localparam int CW   = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_owner, w_owner_nxt;
  logic [1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [CW-1:0] r_burst_cnt, w_burst_nxt, w_burst_inc;

  // Owner's command fields, selected from the packed lanes
  logic          w_own_req, w_own_lock, w_own_we;
  logic [SW-1:0] w_own_sel;
  logic [AW-1:0] w_own_addr;
  logic [DW-1:0] w_own_wdata;

  logic          w_xfer;
  logic [2:0]    w_others;
  logic [2:0]    w_search_mask;
  logic          w_new_grant;
  logic [1:0]    w_winner;

  // Registered memory command and read-return path
  logic          r_cwr, r_crd;
  logic [SW-1:0] r_csel;
  logic [AW-1:0] r_caddr_wr, r_caddr_rd;
  logic [DW-1:0] r_cdata_wr, r_rdata;
  logic [2:0]    r_rvalid;
  logic [1:0]    r_rd_owner;

  // First requester in mask, searching upward (mod 3) from start
  function automatic logic [1:0] f_pick(input logic [2:0] mask, input logic [1:0] start);
    logic [2:0] sum;
    f_pick = start;
    // Walk from the farthest slot back to start so the nearest hit wins
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, start} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (mask[sum[1:0]]) f_pick = sum[1:0];
    end
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_own_req   = 1'b0;
    w_own_lock  = 1'b0;
    w_own_we    = 1'b0;
    w_own_sel   = '0;
    w_own_addr  = '0;
    w_own_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == 2'(i)) begin
        w_own_req   = bus.req[i];
        w_own_lock  = bus.lock[i];
        w_own_we    = bus.we[i];
        w_own_sel   = bus.sel[i*SW +: SW];
        w_own_addr  = bus.addr[i*AW +: AW];
        w_own_wdata = bus.wdata[i*DW +: DW];
      end
    end
  end

  assign w_xfer      = (r_state == S_GRANT) && w_own_req;
  assign w_others    = bus.req & ~(3'b001 << r_owner);
  assign w_burst_inc = (r_burst_cnt == CW'(MAX_BURST)) ? r_burst_cnt : r_burst_cnt + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_burst_nxt   = r_burst_cnt;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_new_grant   = 1'b0;
    w_search_mask = '0;

    case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_new_grant   = 1'b1;
          w_search_mask = bus.req;
        end
      end
      S_GRANT: begin
        if (!w_own_req) begin
          // Owner released: hand over on this same edge if anyone is waiting
          if (|bus.req) begin
            w_new_grant   = 1'b1;
            w_search_mask = bus.req;
          end else begin
            w_state_nxt = S_IDLE;
            w_burst_nxt = '0;
          end
        end else if ((w_burst_inc == CW'(MAX_BURST)) && !w_own_lock && (|w_others)) begin
          // Burst quota used up and someone else waits: preempt, owner excluded
          w_new_grant   = 1'b1;
          w_search_mask = w_others;
        end else begin
          w_burst_nxt = w_burst_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_winner = f_pick(w_search_mask, r_rr_ptr);
    if (w_new_grant) begin
      w_state_nxt = S_GRANT;
      w_owner_nxt = w_winner;
      w_burst_nxt = '0;
`ifdef LMEM_ARB_RR_EN
      w_rr_ptr_nxt = (w_winner == 2'd2) ? 2'd0 : w_winner + 2'd1;
`else
      // Search always starts at r0, which is fixed priority
      w_rr_ptr_nxt = 2'd0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= 2'd0;
      r_burst_cnt <= '0;
      r_rr_ptr    <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cwr      <= 1'b0;
      r_crd      <= 1'b0;
      r_csel     <= '0;
      r_caddr_wr <= '0;
      r_caddr_rd <= '0;
      r_cdata_wr <= '0;
      r_rdata    <= '0;
      r_rvalid   <= '0;
      r_rd_owner <= 2'd0;
    end else begin
      r_cwr <= 1'b0;
      r_crd <= 1'b0;
      if (w_xfer) begin
        r_cwr  <= w_own_we;
        r_crd  <= ~w_own_we;
        r_csel <= w_own_sel;
        if (w_own_we) begin
          r_caddr_wr <= w_own_addr;
          r_cdata_wr <= w_own_wdata;
        end else begin
          r_caddr_rd <= w_own_addr;
          r_rd_owner <= r_owner;
        end
      end
      // A read strobed last cycle returns now, tagged with its issuer
      r_rvalid <= '0;
      if (r_crd) begin
        r_rdata  <= bus.cdata_rd;
        r_rvalid <= 3'b001 << r_rd_owner;
      end
    end
  end

  assign bus.gnt      = (r_state == S_GRANT) ? (3'b001 << r_owner) : 3'b000;
  assign bus.rdata    = r_rdata;
  assign bus.rvalid   = r_rvalid;
  assign bus.cwr      = r_cwr;
  assign bus.crd      = r_crd;
  assign bus.csel     = r_csel;
  assign bus.caddr_wr = r_caddr_wr;
  assign bus.caddr_rd = r_caddr_rd;
  assign bus.cdata_wr = r_cdata_wr;
endmodule

// File: tb/tb_lmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lmem_port_arbiter
// Directed scoreboard bench. Tests push requester commands plus the expected
// memory-command order, read returns and grant trace; a driver process plays
// the three requesters, a monitor process compares whatever the DUT presents.
// Requester r uses csel = r+1 so each memory command identifies its issuer.
// Memory model: word at address a reads as a*3+1.
// -----------------------------------------------------------------------------
module tb_lmem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 20;
  localparam int SW = 3;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lmem_port_arbiter_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();

  lmem_port_arbiter #(.AW(AW), .DW(DW), .SW(SW), .MAX_BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.cdata_rd = DW'(32'(bus.caddr_rd) * 3 + 1);

  typedef struct {
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          lock;
    logic          drop;   // release req for one cycle after this transfer
  } cmd_t;

  typedef struct {
    logic          wr;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;    // cycles since previous command; 0 = don't care
  } exp_cmd_t;

  typedef struct {
    logic [2:0]    rvalid;
    logic [DW-1:0] rdata;
  } exp_rd_t;

  cmd_t       rq [3][$];
  exp_cmd_t   exp_cmd_q[$];
  exp_rd_t    exp_rd_q[$];
  logic [2:0] exp_gnt_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit cmd_chk_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},      bus.gnt,      0);
    check({tag, "_rvalid"},   bus.rvalid,   0);
    check({tag, "_cwr"},      bus.cwr,      0);
    check({tag, "_crd"},      bus.crd,      0);
    check({tag, "_csel"},     bus.csel,     0);
    check({tag, "_caddr_wr"}, bus.caddr_wr, 0);
    check({tag, "_caddr_rd"}, bus.caddr_rd, 0);
    check({tag, "_cdata_wr"}, bus.cdata_wr, 0);
    check({tag, "_rdata"},    bus.rdata,    0);
  endtask

  task automatic push_cmd(input int r, input logic we, input int a, input int d,
                          input logic lk, input logic dr);
    cmd_t c;
    c.we = we; c.sel = SW'(r + 1); c.addr = AW'(a); c.wdata = DW'(d);
    c.lock = lk; c.drop = dr;
    rq[r].push_back(c);
  endtask

  task automatic exp_wr(input int r, input int a, input int d, input int gap);
    exp_cmd_t e;
    e.wr = 1'b1; e.sel = SW'(r + 1); e.addr = AW'(a); e.data = DW'(d); e.gap = gap;
    exp_cmd_q.push_back(e);
  endtask

  task automatic exp_rd(input int r, input int a, input int d, input int gap);
    exp_cmd_t e;
    exp_rd_t  x;
    e.wr = 1'b0; e.sel = SW'(r + 1); e.addr = AW'(a); e.data = '0; e.gap = gap;
    exp_cmd_q.push_back(e);
    x.rvalid = 3'b001 << r; x.rdata = DW'(d);
    exp_rd_q.push_back(x);
  endtask

  function automatic int pending();
    return rq[0].size() + rq[1].size() + rq[2].size() +
           exp_cmd_q.size() + exp_rd_q.size() + exp_gnt_q.size();
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while (pending() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    check({name, "_drain"}, pending(), 0);
  endtask

  // Requester driver: a lane advances to its next command after each transfer edge
  initial begin
    logic [2:0] xfer;
    logic       drop_now;
    bus.req = '0; bus.lock = '0; bus.we = '0;
    bus.sel = '0; bus.addr = '0; bus.wdata = '0;
    forever begin
      @(negedge clk);
      xfer = bus.req & bus.gnt;
      @(posedge clk);
      #1;
      for (int r = 0; r < 3; r++) begin
        drop_now = 1'b0;
        if (xfer[r] && rq[r].size() != 0) begin
          drop_now = rq[r][0].drop;
          void'(rq[r].pop_front());
        end
        if (rq[r].size() != 0 && !drop_now) begin
          bus.req[r]               = 1'b1;
          bus.we[r]                = rq[r][0].we;
          bus.lock[r]              = rq[r][0].lock;
          bus.sel[r*SW +: SW]      = rq[r][0].sel;
          bus.addr[r*AW +: AW]     = rq[r][0].addr;
          bus.wdata[r*DW +: DW]    = rq[r][0].wdata;
        end else begin
          bus.req[r]  = 1'b0;
          bus.lock[r] = 1'b0;
        end
      end
    end
  end

  // Monitor: compares grant changes, memory commands and read returns
  initial begin
    logic [2:0] prev_gnt;
    int         last_cmd_cyc;
    int         rd_cyc_q[$];
    exp_cmd_t   e;
    exp_rd_t    x;
    prev_gnt = 3'b000;
    last_cmd_cyc = -100;
    forever begin
      @(negedge clk);
      if (bus.gnt !== prev_gnt) begin
        if (exp_gnt_q.size() == 0) check("gnt_unexpected", bus.gnt, prev_gnt);
        else check("gnt_seq", bus.gnt, exp_gnt_q.pop_front());
        prev_gnt = bus.gnt;
      end
      if (bus.cwr || bus.crd) begin
        check("cwr_crd_excl", bus.cwr & bus.crd, 0);
        if (bus.crd) rd_cyc_q.push_back(cyc);
        if (cmd_chk_en) begin
          if (exp_cmd_q.size() == 0) begin
            check("cmd_unexpected", {bus.cwr, bus.crd}, 2'b00);
          end else begin
            e = exp_cmd_q.pop_front();
            check("cmd_wr", bus.cwr, e.wr);
            check("cmd_sel", bus.csel, e.sel);
            if (e.wr) begin
              check("caddr_wr", bus.caddr_wr, e.addr);
              check("cdata_wr", bus.cdata_wr, e.data);
            end else begin
              check("caddr_rd", bus.caddr_rd, e.addr);
            end
            if (e.gap > 0) check("cmd_gap", cyc - last_cmd_cyc, e.gap);
          end
        end
        last_cmd_cyc = cyc;
      end
      if (bus.rvalid != 3'b000) begin
        if (rd_cyc_q.size() != 0) check("rd_latency", cyc - rd_cyc_q.pop_front(), 1);
        if (exp_rd_q.size() == 0) begin
          check("rvalid_unexpected", bus.rvalid, 0);
        end else begin
          x = exp_rd_q.pop_front();
          check("rvalid", bus.rvalid, x.rvalid);
          check("rdata", bus.rdata, x.rdata);
        end
      end
      if (reset) rd_cyc_q.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("rst");
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("post_rst");

    // r0 alone: 4 back-to-back writes
    for (int k = 0; k < 4; k++) begin
      push_cmd(0, 1'b1, k, 5 + k, 1'b0, 1'b0);
      exp_wr(0, k, 5 + k, (k == 0) ? 0 : 1);
    end
    exp_gnt_q.push_back(3'b001); exp_gnt_q.push_back(3'b000);
    wait_drain("t1_r0_writes");

    // r1 back-to-back reads of 64, 65
    push_cmd(1, 1'b0, 64, 0, 1'b0, 1'b0);
    push_cmd(1, 1'b0, 65, 0, 1'b0, 1'b0);
    exp_rd(1, 64, 193, 0);
    exp_rd(1, 65, 196, 1);
    exp_gnt_q.push_back(3'b010); exp_gnt_q.push_back(3'b000);
    wait_drain("t2_r1_reads");

    // r0 streaming vs r2 streaming, no lock: preempt after 8
    for (int k = 0; k < 10; k++) push_cmd(0, 1'b1, 100 + k, 1000 + k, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)  push_cmd(2, 1'b0, 10 + k, 0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)  exp_wr(0, 100 + k, 1000 + k, (k == 0) ? 0 : 1);
    exp_rd(2, 10, 31, 1);
    exp_rd(2, 11, 34, 1);
    exp_rd(2, 12, 37, 1);
    exp_wr(0, 108, 1008, 2);
    exp_wr(0, 109, 1009, 1);
    exp_gnt_q.push_back(3'b001); exp_gnt_q.push_back(3'b100);
    exp_gnt_q.push_back(3'b001); exp_gnt_q.push_back(3'b000);
    wait_drain("t3_burst_preempt");

    // Same with lock[0]=1: r0 keeps the port for all 12
    for (int k = 0; k < 12; k++) push_cmd(0, 1'b1, 200 + k, 2000 + k, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++)  push_cmd(2, 1'b0, 20 + k, 0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) exp_wr(0, 200 + k, 2000 + k, (k == 0) ? 0 : 1);
    exp_rd(2, 20, 61, 2);
    exp_rd(2, 21, 64, 1);
    exp_gnt_q.push_back(3'b001); exp_gnt_q.push_back(3'b100); exp_gnt_q.push_back(3'b000);
    wait_drain("t4_lock");

    // Reset while an r1 read is in flight: no rvalid may follow
    cmd_chk_en = 1'b0;
    for (int k = 0; k < 4; k++) push_cmd(1, 1'b0, 300 + k, 0, 1'b0, 1'b0);
    exp_gnt_q.push_back(3'b010); exp_gnt_q.push_back(3'b000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.crd && n < 50);
    check("t5_crd_seen", bus.crd, 1);
    reset = 1'b1;
    rq[1].delete();
    #1 check_all_zero("t5_rst_async");
    @(posedge clk);
    #1 check_all_zero("t5_rst_next");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    cmd_chk_en = 1'b1;
    wait_drain("t5_reset_mid");

    // All three issuing single transfers (req dropped for a cycle after each)
    push_cmd(0, 1'b1, 40, 'h40, 1'b0, 1'b1);
    push_cmd(0, 1'b1, 41, 'h41, 1'b0, 1'b1);
    push_cmd(1, 1'b0, 50, 0, 1'b0, 1'b1);
    push_cmd(1, 1'b0, 51, 0, 1'b0, 1'b1);
    push_cmd(2, 1'b0, 60, 0, 1'b0, 1'b1);
    push_cmd(2, 1'b0, 61, 0, 1'b0, 1'b1);
`ifdef LMEM_ARB_RR_EN
    exp_wr(0, 40, 'h40, 0);
    exp_rd(1, 50, 151, 2);
    exp_rd(2, 60, 181, 2);
    exp_wr(0, 41, 'h41, 2);
    exp_rd(1, 51, 154, 2);
    exp_rd(2, 61, 184, 2);
    exp_gnt_q.push_back(3'b001); exp_gnt_q.push_back(3'b010); exp_gnt_q.push_back(3'b100);
    exp_gnt_q.push_back(3'b001); exp_gnt_q.push_back(3'b010); exp_gnt_q.push_back(3'b100);
    exp_gnt_q.push_back(3'b000);
`else
    exp_wr(0, 40, 'h40, 0);
    exp_rd(1, 50, 151, 2);
    exp_wr(0, 41, 'h41, 2);
    exp_rd(1, 51, 154, 2);
    exp_rd(2, 60, 181, 2);
    exp_rd(2, 61, 184, 3);
    exp_gnt_q.push_back(3'b001); exp_gnt_q.push_back(3'b010); exp_gnt_q.push_back(3'b001);
    exp_gnt_q.push_back(3'b010); exp_gnt_q.push_back(3'b100); exp_gnt_q.push_back(3'b000);
    exp_gnt_q.push_back(3'b100); exp_gnt_q.push_back(3'b000);
`endif
    wait_drain("t6_arb_order");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
